avalon_bus_master: RTL and testbench

- Avalon-MM initiator. Converts single-beat load/store requests from a core-side valid/ready port into Avalon read/write transfers toward peripheral slaves such as the GPIO bus interface.
- Honours `i_AV_WaitRequest`, captures registered read data at a fixed latency, and aborts hung transfers with an error response after a timeout.
- Sits between the CPU data port and the peripheral address decoder.

---
 rtl/avalon_bus_master_pkg.sv | 13 +
 rtl/avalon_bus_master_if.sv | 41 ++++
 rtl/avalon_bus_master_timeout.sv | 24 ++
 rtl/avalon_bus_master.sv | 96 +++++++++
 tb/tb_avalon_bus_master.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/avalon_bus_master_pkg.sv
// Shared definitions for the Avalon-MM initiator: bus widths, parameter
// defaults and the 2-bit transfer FSM encoding.
package avalon_bus_master_pkg;
  localparam int DATA_W             = 32;
  localparam int BE_W               = 4;
  localparam int DEF_READ_LATENCY   = 1;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUS    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_RSP    = 2'd3;
endpackage

// File: rtl/avalon_bus_master_if.sv
// Core-side request/response port plus Avalon-MM initiator signals.
// "master" is the initiator's view, "slave" is the core + peripheral side.
interface avalon_bus_master_if #(
  parameter int ADDR_WIDTH = 32
);
  import avalon_bus_master_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BE_W-1:0]       req_byteen;
  logic [DATA_W-1:0]     req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] av_address;
  logic [BE_W-1:0]       av_byteen;
  logic                  av_read;
  logic                  av_write;
  logic [DATA_W-1:0]     av_writedata;
  logic [DATA_W-1:0]     av_readdata;
  logic                  av_waitrequest;

  modport master (
    input  req_valid, req_write, req_addr, req_byteen, req_wdata, rsp_ready,
           av_readdata, av_waitrequest,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           av_address, av_byteen, av_read, av_write, av_writedata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_byteen, req_wdata, rsp_ready,
           av_readdata, av_waitrequest,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           av_address, av_byteen, av_read, av_write, av_writedata
  );
endinterface

// File: rtl/avalon_bus_master_timeout.sv
// Saturating wait-request counter; tc flags the last cycle a stall is
// tolerated before the owning initiator aborts the transfer.
module avalon_bus_master_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)         cnt <= '0;
    else if (clr)       cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == TERM);
endmodule

// File: rtl/avalon_bus_master.sv
// Single-outstanding Avalon-MM initiator: one core request becomes one
// Avalon read/write, with fixed read latency capture and stall timeout.
module avalon_bus_master
  import avalon_bus_master_pkg::*;
#(
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  avalon_bus_master_if.master bus
);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  logic [1:0]       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             to_tc;

  assign bus.req_ready = (state == ST_IDLE);

  // Counter is held clear in IDLE so every transfer starts from zero.
  avalon_bus_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == ST_IDLE),
    .en    ((state == ST_BUS) && bus.av_waitrequest),
    .tc    (to_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      lat_cnt          <= '0;
      bus.av_address   <= '0;
      bus.av_byteen    <= '0;
      bus.av_writedata <= '0;
      bus.av_read      <= 1'b0;
      bus.av_write     <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            bus.av_address   <= bus.req_addr;
            bus.av_byteen    <= bus.req_byteen;
            bus.av_writedata <= bus.req_wdata;
            bus.av_read      <= ~bus.req_write;
            bus.av_write     <= bus.req_write;
            state            <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Acceptance is checked first so it wins over a same-edge timeout.
          if (!bus.av_waitrequest) begin
            bus.av_read  <= 1'b0;
            bus.av_write <= 1'b0;
            if (bus.av_write) begin
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= 1'b0;
              bus.rsp_valid <= 1'b1;
              state         <= ST_RSP;
            end else begin
              lat_cnt <= LAT_W'(READ_LATENCY);
              state   <= ST_RDWAIT;
            end
          end else if (to_tc) begin
            bus.av_read   <= 1'b0;
            bus.av_write  <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RSP;
          end
        end
        ST_RDWAIT: begin
          if (lat_cnt == LAT_W'(1)) begin
            bus.rsp_rdata <= bus.av_readdata;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RSP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_bus_master.sv
// Directed + randomized transfers checked against a transaction-level model
// of strobe length, read-capture timing, timeout and response contents.
module tb_avalon_bus_master;
  localparam int RL = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_bus_master_if #(.ADDR_WIDTH(32)) bus ();

  avalon_bus_master #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One transfer: slave stalls nwait cycles, core delays rsp_ready by hold cycles.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int nwait, input int hold);
    logic        tmo;
    int          strobe_cyc;
    logic [31:0] exp_rd;
    tmo        = (nwait >= TO);
    strobe_cyc = tmo ? TO : nwait + 1;
    exp_rd     = (wr || tmo) ? 32'h0 : rd;

    chk1("idle_req_ready", bus.req_ready, 1'b1);
    bus.req_valid      = 1'b1;
    bus.req_write      = wr;
    bus.req_addr       = addr;
    bus.req_byteen     = be;
    bus.req_wdata      = wd;
    bus.av_waitrequest = (nwait > 0);
    step();

    for (int c = 0; c < strobe_cyc; c++) begin
      chk1("bus_av_read", bus.av_read, !wr);
      chk1("bus_av_write", bus.av_write, wr);
      chk("bus_av_address", bus.av_address, addr);
      chk("bus_av_byteen", {28'h0, bus.av_byteen}, {28'h0, be});
      if (wr) chk("bus_av_writedata", bus.av_writedata, wd);
      chk1("bus_req_ready", bus.req_ready, 1'b0);
      chk1("bus_rsp_valid", bus.rsp_valid, 1'b0);
      bus.av_waitrequest = (c < nwait);
      bus.req_valid      = 1'($urandom_range(0, 1));
      bus.req_write      = 1'($urandom_range(0, 1));
      bus.req_addr       = $urandom;
      bus.req_byteen     = 4'($urandom);
      bus.req_wdata      = $urandom;
      step();
    end

    if (!wr && !tmo) begin
      for (int k = 1; k <= RL; k++) begin
        chk1("rdwait_strobe", bus.av_read | bus.av_write, 1'b0);
        chk1("rdwait_rsp_valid", bus.rsp_valid, 1'b0);
        bus.av_readdata    = (k == RL) ? rd : $urandom;
        bus.av_waitrequest = 1'($urandom_range(0, 1));
        step();
      end
    end

    for (int h = 0; h <= hold; h++) begin
      chk1("rsp_valid", bus.rsp_valid, 1'b1);
      chk("rsp_rdata", bus.rsp_rdata, exp_rd);
      chk1("rsp_err", bus.rsp_err, tmo);
      chk1("rsp_req_ready", bus.req_ready, 1'b0);
      chk1("rsp_strobe", bus.av_read | bus.av_write, 1'b0);
      bus.av_readdata = $urandom;
      bus.rsp_ready   = (h == hold);
      bus.req_valid   = 1'b1;
      step();
    end
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    chk1("post_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("post_req_ready", bus.req_ready, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_av_read"}, bus.av_read, 1'b0);
    chk1({tag, "_av_write"}, bus.av_write, 1'b0);
    chk({tag, "_av_address"}, bus.av_address, 32'h0);
    chk({tag, "_av_byteen"}, {28'h0, bus.av_byteen}, 32'h0);
    chk({tag, "_av_writedata"}, bus.av_writedata, 32'h0);
    chk1({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk1({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    chk1({tag, "_req_ready"}, bus.req_ready, 1'b1);
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_write      = 1'b0;
    bus.req_addr       = '0;
    bus.req_byteen     = '0;
    bus.req_wdata      = '0;
    bus.rsp_ready      = 1'b0;
    bus.av_readdata    = '0;
    bus.av_waitrequest = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    xfer(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 0, 0);
    xfer(1'b0, 32'h0000_0004, 4'hF, 32'h0, 32'h1234_5678, 0, 0);
    xfer(1'b0, 32'h0000_0008, 4'h3, 32'h0, 32'hA5A5_0001, 3, 0);
    xfer(1'b0, 32'h0000_0020, 4'hF, 32'h0, 32'hFFFF_FFFF, 1000, 1);
    xfer(1'b1, 32'h0000_0024, 4'h5, 32'hCAFE_F00D, 32'h0, 0, 0);
    xfer(1'b0, 32'h0000_0030, 4'hF, 32'h0, 32'h0BAD_CAFE, 1, 5);
    xfer(1'b1, 32'h0000_0034, 4'hC, 32'h1111_2222, 32'h0, TO - 1, 0);
    xfer(1'b0, 32'h0000_0038, 4'hF, 32'h0, 32'h3333_4444, TO - 1, 0);
    xfer(1'b1, 32'h0000_003C, 4'hF, 32'h5555_6666, 32'h0, TO, 2);

    for (int i = 0; i < 30; i++)
      xfer(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
           int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)));

    bus.req_valid      = 1'b1;
    bus.req_write      = 1'b0;
    bus.req_addr       = 32'h0000_0100;
    bus.req_byteen     = 4'hF;
    bus.av_waitrequest = 1'b1;
    step();
    bus.req_valid = 1'b0;
    repeat (3) begin
      chk1("pre_rst_av_read", bus.av_read, 1'b1);
      step();
    end
    rst_n = 1'b0;
    step();
    chk_reset_outputs("mid_rst");
    rst_n = 1'b1;
    bus.av_waitrequest = 1'b0;
    repeat (5) begin
      step();
      chk1("after_rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("after_rst_strobe", bus.av_read | bus.av_write, 1'b0);
      chk1("after_rst_req_ready", bus.req_ready, 1'b1);
    end
    xfer(1'b0, 32'h0000_0104, 4'hF, 32'h0, 32'h7777_8888, 2, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
